yarvi_uart_tx: RTL

- Byte-stream-to-serial transmitter: the far end of the SoC's ready/valid byte output stream (rx_valid/rx_ready/rx_data).
- Accepts one byte per valid/ready handshake and serializes it as a standard asynchronous 8N1 frame on a single line, LSB first.
- Sits between yarvi_soc and the board UART pin, or a serial monitor in simulation, so console output leaves the SoC as real serial traffic.

---
 rtl/yarvi_uart_tx.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/yarvi_uart_tx.sv
// yarvi_uart_tx: byte-stream to asynchronous serial transmitter.
//
// Accepts one byte per valid/ready handshake and sends it LSB first as an
// 8N1 frame: start bit (0), eight data bits, stop bit (1). Each bit level
// is held for exactly DIVISOR clock cycles.
//
// Build option:
//   YARVI_UART_TX_PARITY_EN - when defined, an even-parity bit (XOR of the
//                             eight data bits) is sent between the last data
//                             bit and the stop bit, making an 8E1 frame.
//
// Parameters:
//   DIVISOR - clock cycles per serial bit (2..65535)
//   CW      - width of the bit-period counter, 2**CW > DIVISOR
//
// Ports:
//   clock - rising-edge clock
//   reset - asynchronous active-low reset
//   valid - a byte is offered on data
//   ready - transmitter accepts a byte this cycle (combinational from state)
//   data  - byte to send, sampled only on the handshake edge
//   txd   - registered serial line, idles high
//   busy  - registered, high whenever a frame is in progress
module yarvi_uart_tx #(
  parameter int DIVISOR = 434,
  parameter int CW      = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       valid,
  output logic       ready,
  input  logic [7:0] data,
  output logic       txd,
  output logic       busy
);

  localparam logic [CW-1:0] RELOAD = CW'(DIVISOR - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef YARVI_UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic [2:0]      bit_q,   bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            txd_q,   txd_d;
  logic            busy_q,  busy_d;
`ifdef YARVI_UART_TX_PARITY_EN
  logic            par_q,   par_d;
`endif

  logic accept;
  logic bit_done;

  assign accept   = valid & ready;
  // The counter reaching zero marks the last cycle of the current bit level.
  assign bit_done = (cnt_q == '0);

  // State register (plus datapath and registered outputs)
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
`ifdef YARVI_UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
`ifdef YARVI_UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept)   state_d = S_START;
      S_START: if (bit_done) state_d = S_DATA;
      S_DATA: begin
        if (bit_done && (bit_q == 3'd7)) begin
`ifdef YARVI_UART_TX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end
      end
`ifdef YARVI_UART_TX_PARITY_EN
      S_PARITY: if (bit_done) state_d = S_STOP;
`endif
      // A byte offered on the final stop cycle starts the next frame with
      // no idle gap.
      S_STOP:  if (bit_done) state_d = accept ? S_START : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bit counter, bit index and shift register
  always_comb begin
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
`ifdef YARVI_UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (accept) begin
      cnt_d   = RELOAD;
      bit_d   = 3'd0;
      shift_d = data;
`ifdef YARVI_UART_TX_PARITY_EN
      par_d   = ^data;
`endif
    end else if (state_q != S_IDLE) begin
      if (bit_done) begin
        cnt_d = RELOAD;
        if (state_q == S_DATA) begin
          shift_d = {1'b0, shift_q[7:1]};
          // Wraps 7 -> 0, leaving the index ready for the next frame.
          bit_d   = bit_q + 3'd1;
        end
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  // Outputs: txd is the registered line level of the current state, so the
  // start bit appears on the edge after the accepting edge.
  always_comb begin
    ready  = (state_q == S_IDLE) || ((state_q == S_STOP) && bit_done);
    busy_d = (state_d != S_IDLE);
    txd_d  = 1'b1;
    unique case (state_q)
      S_IDLE:   txd_d = 1'b1;
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = shift_q[0];
`ifdef YARVI_UART_TX_PARITY_EN
      S_PARITY: txd_d = par_q;
`endif
      S_STOP:   txd_d = 1'b1;
      default:  txd_d = 1'b1;
    endcase
  end

  assign txd  = txd_q;
  assign busy = busy_q;

endmodule
